// File: rtl/calc_sequencer_if.sv
// Bus bundle between the calculator frame sequencer and its peripherals:
// UART RX/TX, the digit concatenator and the ALU.
interface calc_sequencer_if;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  dato;
  logic        num_ready;
  logic        fin;
  logic [31:0] resultado;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_op;
  logic [31:0] alu_res;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        busy;
  logic        error;

  modport master (
    input  rx_data, rx_done, resultado, alu_res, tx_busy,
    output dato, num_ready, fin, alu_a, alu_b, alu_op, tx_data, tx_start, busy, error
  );

  modport slave (
    output rx_data, rx_done, resultado, alu_res, tx_busy,
    input  dato, num_ready, fin, alu_a, alu_b, alu_op, tx_data, tx_start, busy, error
  );
endinterface

// File: rtl/calc_sequencer.sv
// Frame controller for the UART calculator: parses <digits A><op><digits B>'=',
// drives the concatenator and ALU, and returns the 32-bit result as 4 bytes MSB first.
module calc_sequencer #(
  parameter int MAX_DIGITS = 9,
  parameter int CONCAT_LAT = 2,
  parameter int ALU_LAT    = 1
) (
  input logic              clk,
  input logic              reset,
  calc_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_READ_A, S_WAIT_A, S_READ_B, S_WAIT_B,
    S_EXEC, S_SEND, S_SEND_WAIT, S_FLUSH
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);
  localparam logic [3:0] CAT_LAT = 4'(CONCAT_LAT);
  localparam logic [3:0] EXE_LAT = 4'(ALU_LAT);

  state_t      r_state,     w_state_nxt;
  logic [3:0]  r_cnt,       w_cnt_nxt;
  logic [3:0]  r_wait,      w_wait_nxt;
  logic [1:0]  r_idx,       w_idx_nxt;
  logic [7:0]  r_dato,      w_dato_nxt;
  logic        r_num_ready, w_num_ready_nxt;
  logic        r_fin,       w_fin_nxt;
  logic [31:0] r_alu_a,     w_alu_a_nxt;
  logic [31:0] r_alu_b,     w_alu_b_nxt;
  logic [1:0]  r_alu_op,    w_alu_op_nxt;
  logic [31:0] r_result,    w_result_nxt;
  logic [7:0]  r_tx_data,   w_tx_data_nxt;
  logic        r_tx_start,  w_tx_start_nxt;
  logic        r_error,     w_error_nxt;

  logic        w_is_digit;
  logic        w_is_op;
  logic        w_is_eq;
  logic [1:0]  w_op_code;

  assign w_is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
  assign w_is_eq    = (bus.rx_data == 8'h3D);

  always_comb begin
    w_is_op   = 1'b1;
    w_op_code = 2'b00;
    case (bus.rx_data)
      8'h2B:   w_op_code = 2'b00;
      8'h2D:   w_op_code = 2'b01;
      8'h26:   w_op_code = 2'b10;
      8'h7C:   w_op_code = 2'b11;
      default: w_is_op   = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal gets a default up front so no path leaves one unassigned and infers a latch.
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_wait_nxt      = r_wait;
    w_idx_nxt       = r_idx;
    w_dato_nxt      = r_dato;
    w_num_ready_nxt = 1'b0;
    w_fin_nxt       = 1'b0;
    w_alu_a_nxt     = r_alu_a;
    w_alu_b_nxt     = r_alu_b;
    w_alu_op_nxt    = r_alu_op;
    w_result_nxt    = r_result;
    w_tx_data_nxt   = r_tx_data;
    w_tx_start_nxt  = 1'b0;
    w_error_nxt     = r_error;

    unique case (r_state)
      S_IDLE, S_READ_A, S_READ_B: begin
        if (bus.rx_done) begin
          if (w_is_digit && r_cnt != MAX_CNT) begin
            w_dato_nxt      = {4'h0, bus.rx_data[3:0]};
            w_num_ready_nxt = 1'b1;
            w_cnt_nxt       = r_cnt + 4'd1;
            if (r_state == S_IDLE) begin
              w_state_nxt = S_READ_A;
              w_error_nxt = 1'b0;
            end
          end else if (w_is_op && r_state == S_READ_A && r_cnt != 4'd0) begin
            w_alu_op_nxt = w_op_code;
            w_fin_nxt    = 1'b1;
            w_wait_nxt   = 4'd0;
            w_state_nxt  = S_WAIT_A;
          end else if (w_is_eq && r_state == S_READ_B && r_cnt != 4'd0) begin
            w_fin_nxt   = 1'b1;
            w_wait_nxt  = 4'd0;
            w_state_nxt = S_WAIT_B;
          end else begin
            // Frame error: flush any partially built operand out of the concatenator.
            w_error_nxt = 1'b1;
            if (r_cnt != 4'd0) begin
              w_fin_nxt   = 1'b1;
              w_wait_nxt  = 4'd0;
              w_state_nxt = S_FLUSH;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end

      S_WAIT_A: begin
        if (r_wait == CAT_LAT) begin
          w_alu_a_nxt = bus.resultado;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_READ_B;
        end else begin
          w_wait_nxt = r_wait + 4'd1;
        end
      end

      S_WAIT_B: begin
        if (r_wait == CAT_LAT) begin
          w_alu_b_nxt = bus.resultado;
          w_cnt_nxt   = 4'd0;
          w_wait_nxt  = 4'd0;
          w_state_nxt = S_EXEC;
        end else begin
          w_wait_nxt = r_wait + 4'd1;
        end
      end

      S_EXEC: begin
        if (r_wait == EXE_LAT) begin
          w_result_nxt = bus.alu_res;
          w_idx_nxt    = 2'd3;
          w_state_nxt  = S_SEND;
        end else begin
          w_wait_nxt = r_wait + 4'd1;
        end
      end

      S_SEND: begin
        if (!bus.tx_busy) begin
          w_tx_data_nxt  = r_result[{r_idx, 3'b000} +: 8];
          w_tx_start_nxt = 1'b1;
          w_wait_nxt     = 4'd0;
          w_state_nxt    = S_SEND_WAIT;
        end
      end

      S_SEND_WAIT: begin
        // The UART raises busy one cycle after tx_start, so its first cycle here is ignored.
        if (r_wait == 4'd0) begin
          w_wait_nxt = 4'd1;
        end else if (!bus.tx_busy) begin
          if (r_idx != 2'd0) begin
            w_idx_nxt   = r_idx - 2'd1;
            w_state_nxt = S_SEND;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_FLUSH: begin
        if (r_wait == CAT_LAT) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_wait_nxt = r_wait + 4'd1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_wait      <= 4'd0;
      r_idx       <= 2'd3;
      r_dato      <= 8'h00;
      r_num_ready <= 1'b0;
      r_fin       <= 1'b0;
      r_alu_a     <= 32'd0;
      r_alu_b     <= 32'd0;
      r_alu_op    <= 2'b00;
      r_result    <= 32'd0;
      r_tx_data   <= 8'h00;
      r_tx_start  <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_wait      <= w_wait_nxt;
      r_idx       <= w_idx_nxt;
      r_dato      <= w_dato_nxt;
      r_num_ready <= w_num_ready_nxt;
      r_fin       <= w_fin_nxt;
      r_alu_a     <= w_alu_a_nxt;
      r_alu_b     <= w_alu_b_nxt;
      r_alu_op    <= w_alu_op_nxt;
      r_result    <= w_result_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_start  <= w_tx_start_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign bus.dato      = r_dato;
  assign bus.num_ready = r_num_ready;
  assign bus.fin       = r_fin;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_op    = r_alu_op;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_start  = r_tx_start;
  assign bus.error     = r_error;
  assign bus.busy      = (r_state != S_IDLE) && (r_state != S_READ_A);

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a digit concatenator, a 32-bit ALU
// and a UART TX model that stays busy 20 cycles after each start.
module tb_calc_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hold = 1'b0;
  int   tx_cnt;
  int   n_cmp = 0;
  int   n_bad = 0;

  int   nr_count = 0;
  int   fin_count = 0;
  int   txs_count = 0;
  int   viol_tx = 0;
  int   viol_nf = 0;
  logic [7:0] tx_q[$];
  logic [7:0] dato_q[$];

  logic [31:0] acc;
  logic [31:0] stage1;

  calc_sequencer_if bus ();

  calc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.tx_busy = (tx_cnt != 0) || hold;

  // Concatenator: result appears two cycles after the fin pulse.
  always @(posedge clk) begin
    if (reset) begin
      acc <= 32'd0;
      stage1 <= 32'd0;
      bus.resultado <= 32'd0;
    end else begin
      if (bus.num_ready) acc <= acc * 32'd10 + {24'd0, bus.dato};
      if (bus.fin) begin
        stage1 <= acc;
        acc <= 32'd0;
      end
      bus.resultado <= stage1;
    end
  end

  always @(posedge clk) begin
    case (bus.alu_op)
      2'b00:   bus.alu_res <= bus.alu_a + bus.alu_b;
      2'b01:   bus.alu_res <= bus.alu_a - bus.alu_b;
      2'b10:   bus.alu_res <= bus.alu_a & bus.alu_b;
      default: bus.alu_res <= bus.alu_a | bus.alu_b;
    endcase
  end

  always @(posedge clk) begin
    if (reset) begin
      tx_cnt <= 0;
    end else if (bus.tx_start) begin
      tx_cnt <= 20;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (bus.num_ready) begin
      nr_count <= nr_count + 1;
      dato_q.push_back(bus.dato);
    end
    if (bus.fin) fin_count <= fin_count + 1;
    if (bus.tx_start) begin
      txs_count <= txs_count + 1;
      tx_q.push_back(bus.tx_data);
    end
    if (bus.tx_start && bus.tx_busy) viol_tx <= viol_tx + 1;
    if (bus.num_ready && bus.fin) viol_nf <= viol_nf + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_frame(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_tx(input string tag, input int n_total);
    int budget;
    budget = 3000;
    while (tx_q.size() < n_total && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, "_txcount"}, tx_q.size(), n_total);
    budget = 200;
    while (bus.busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic check_tx(input string tag, input int base, input logic [31:0] exp);
    for (int k = 0; k < 4; k++) begin
      if (base + k < tx_q.size())
        check($sformatf("%s_byte%0d", tag, k), {24'd0, tx_q[base + k]}, {24'd0, exp[31 - 8 * k -: 8]});
      else
        check($sformatf("%s_byte%0d_missing", tag, k), base + k, tx_q.size());
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dato"},      {24'd0, bus.dato}, 32'd0);
    check({tag, "_num_ready"}, {31'd0, bus.num_ready}, 32'd0);
    check({tag, "_fin"},       {31'd0, bus.fin}, 32'd0);
    check({tag, "_alu_a"},     bus.alu_a, 32'd0);
    check({tag, "_alu_b"},     bus.alu_b, 32'd0);
    check({tag, "_alu_op"},    {30'd0, bus.alu_op}, 32'd0);
    check({tag, "_tx_data"},   {24'd0, bus.tx_data}, 32'd0);
    check({tag, "_tx_start"},  {31'd0, bus.tx_start}, 32'd0);
    check({tag, "_busy"},      {31'd0, bus.busy}, 32'd0);
    check({tag, "_error"},     {31'd0, bus.error}, 32'd0);
  endtask

  initial begin
    int base_tx;
    int base_nr;
    int base_fin;
    int base_txs;
    int base_d;
    logic [31:0] exp_res;

    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // "12+34=" : basic addition
    base_tx = tx_q.size(); base_nr = nr_count; base_fin = fin_count; base_d = dato_q.size();
    send_frame("12+34=");
    wait_tx("add", base_tx + 4);
    check("add_nr_count", nr_count - base_nr, 4);
    check("add_fin_count", fin_count - base_fin, 2);
    for (int k = 0; k < 4; k++)
      check($sformatf("add_dato%0d", k), {24'd0, dato_q[base_d + k]}, k + 1);
    check("add_alu_a", bus.alu_a, 32'd12);
    check("add_alu_b", bus.alu_b, 32'd34);
    check("add_alu_op", {30'd0, bus.alu_op}, 32'd0);
    check_tx("add", base_tx, 32'd46);
    check("add_error", {31'd0, bus.error}, 32'd0);

    // Nine-digit operand with subtraction
    base_tx = tx_q.size();
    send_frame("981498149-1=");
    wait_tx("sub", base_tx + 4);
    check("sub_alu_a", bus.alu_a, 32'd981498149);
    check("sub_alu_b", bus.alu_b, 32'd1);
    check("sub_alu_op", {30'd0, bus.alu_op}, 32'd1);
    exp_res = 32'd981498148;
    check_tx("sub", base_tx, exp_res);

    // Operator with no digits
    base_nr = nr_count; base_fin = fin_count; base_txs = txs_count;
    send_byte("+");
    check("opfirst_error", {31'd0, bus.error}, 32'd1);
    check("opfirst_no_nr", nr_count - base_nr, 0);
    check("opfirst_no_fin", fin_count - base_fin, 0);
    check("opfirst_idle", {31'd0, bus.busy}, 32'd0);
    send_byte("5");
    check("opfirst_digit_clears", {31'd0, bus.error}, 32'd0);
    send_byte("=");
    repeat (10) @(negedge clk);
    check("opfirst_eq_error", {31'd0, bus.error}, 32'd1);
    check("opfirst_flush_fin", fin_count - base_fin, 1);
    check("opfirst_no_tx", txs_count - base_txs, 0);

    base_tx = tx_q.size();
    send_frame("1|2=");
    wait_tx("or", base_tx + 4);
    check("or_alu_op", {30'd0, bus.alu_op}, 32'd3);
    check_tx("or", base_tx, 32'd3);
    check("or_error", {31'd0, bus.error}, 32'd0);

    // Ten digits: the 10th overflows and the partial operand is flushed
    base_nr = nr_count; base_fin = fin_count; base_txs = txs_count;
    send_frame("1111111111");
    repeat (10) @(negedge clk);
    check("ovf_nr_count", nr_count - base_nr, 9);
    check("ovf_error", {31'd0, bus.error}, 32'd1);
    check("ovf_fin_count", fin_count - base_fin, 1);
    check("ovf_idle", {31'd0, bus.busy}, 32'd0);
    check("ovf_no_tx", txs_count - base_txs, 0);

    // TX held busy: no start until it falls
    base_tx = tx_q.size(); base_txs = txs_count;
    hold = 1'b1;
    send_frame("7&3=");
    repeat (50) @(negedge clk);
    check("hold_no_tx", txs_count - base_txs, 0);
    check("hold_busy", {31'd0, bus.busy}, 32'd1);
    hold = 1'b0;
    wait_tx("hold", base_tx + 4);
    check_tx("hold", base_tx, 32'd3);
    check("hold_and_result_a", bus.alu_a, 32'd7);

    // Reset in the middle of transmission
    base_tx = tx_q.size();
    send_frame("9+9=");
    begin
      int budget;
      budget = 2000;
      while (tx_q.size() < base_tx + 2 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
    end
    check("rst_two_bytes", tx_q.size(), base_tx + 2);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_no_more_tx", tx_q.size(), base_tx + 2);

    base_tx = tx_q.size();
    send_frame("5+5=");
    wait_tx("after_rst", base_tx + 4);
    check_tx("after_rst", base_tx, 32'd10);

    check("tx_start_while_busy", viol_tx, 0);
    check("num_ready_with_fin", viol_nf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
